// File: rtl/acc_unit.sv
// Accumulator with add/sub/shift/load/clear and an optional multi-cycle
// unsigned shift-add multiplier whose 2*WIDTH product lands in {mr_out, acc_out}.
module acc_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      control_signal,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_MUL  = 3'd7
  } op_e;

  state_e state_q, state_d;
  op_e    op_c;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH:0]   add_sum_c;
  logic [WIDTH:0]   sub_dif_c;
  logic [WIDTH:0]   step_sum_c;
  logic [PW-1:0]    prod_step_c;
  logic             last_step_c;
  logic             upd_zn_c;
  logic             unused_ctrl;

  assign unused_ctrl = ^{control_signal[31:22], control_signal[14:0]};

  // Priority decode: only the highest-priority set bit is executed.
  always_comb begin
    op_c = OP_NONE;
    if (control_signal[21])      op_c = OP_CLR;
    else if (control_signal[20]) op_c = OP_LOAD;
    else if (control_signal[19]) op_c = OP_ADD;
    else if (control_signal[18]) op_c = OP_SUB;
    else if (control_signal[17]) op_c = OP_SHL;
    else if (control_signal[16]) op_c = OP_SHR;
    else if (control_signal[15] && (MUL_EN != 0)) op_c = OP_MUL;
  end

  assign add_sum_c = {1'b0, acc_q} + {1'b0, acc_in};
  assign sub_dif_c = {1'b0, acc_q} - {1'b0, acc_in};

  // One shift-add step: the low half starts as the multiplier and is consumed LSB first.
  assign step_sum_c  = {1'b0, prod_q[PW-1:WIDTH]} +
                       (prod_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
  assign prod_step_c = {step_sum_c, prod_q[WIDTH-1:1]};
  assign last_step_c = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = (op_c == OP_MUL) ? S_MUL : S_IDLE;
      S_MUL: begin
        if (op_c == OP_CLR)   state_d = S_IDLE;
        else if (last_step_c) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    acc_d    = acc_q;
    mr_d     = mr_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    upd_zn_c = 1'b0;

    case (state_q)
      S_MUL: begin
        if (op_c == OP_CLR) begin
          acc_d  = '0;
          mr_d   = '0;
          z_d    = 1'b1;
          n_d    = 1'b0;
          c_d    = 1'b0;
          v_d    = 1'b0;
          busy_d = 1'b0;
        end else begin
          prod_d = prod_step_c;
          cnt_d  = cnt_q + CW'(1);
          if (last_step_c) begin
            acc_d  = prod_step_c[WIDTH-1:0];
            mr_d   = prod_step_c[PW-1:WIDTH];
            z_d    = (prod_step_c == '0);
            n_d    = prod_step_c[PW-1];
            c_d    = (prod_step_c[PW-1:WIDTH] != '0);
            v_d    = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        case (op_c)
          OP_CLR: begin
            acc_d = '0;
            mr_d  = '0;
            z_d   = 1'b1;
            n_d   = 1'b0;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
          OP_LOAD: begin
            acc_d    = acc_in;
            c_d      = 1'b0;
            v_d      = 1'b0;
            upd_zn_c = 1'b1;
          end
          OP_ADD: begin
            acc_d    = add_sum_c[WIDTH-1:0];
            c_d      = add_sum_c[WIDTH];
            v_d      = (acc_q[WIDTH-1] == acc_in[WIDTH-1]) &&
                       (add_sum_c[WIDTH-1] != acc_q[WIDTH-1]);
            upd_zn_c = 1'b1;
          end
          OP_SUB: begin
            acc_d    = sub_dif_c[WIDTH-1:0];
            c_d      = sub_dif_c[WIDTH];
            v_d      = (acc_q[WIDTH-1] != acc_in[WIDTH-1]) &&
                       (sub_dif_c[WIDTH-1] != acc_q[WIDTH-1]);
            upd_zn_c = 1'b1;
          end
          OP_SHL: begin
            acc_d    = {acc_q[WIDTH-2:0], 1'b0};
            c_d      = acc_q[WIDTH-1];
            v_d      = 1'b0;
            upd_zn_c = 1'b1;
          end
          OP_SHR: begin
            acc_d    = {1'b0, acc_q[WIDTH-1:1]};
            c_d      = acc_q[0];
            v_d      = 1'b0;
            upd_zn_c = 1'b1;
          end
          OP_MUL: begin
            mcand_d = acc_in;
            prod_d  = {WIDTH'(0), acc_q};
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
          default: ;
        endcase
        if (upd_zn_c) begin
          z_d = (acc_d == '0);
          n_d = acc_d[WIDTH-1];
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mr_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mr_q    <= mr_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign acc_out = acc_q;
  assign mr_out  = mr_q;
  assign flag_z  = z_q;
  assign flag_n  = n_q;
  assign flag_c  = c_q;
  assign flag_v  = v_q;
  assign busy    = (MUL_EN != 0) ? busy_q : 1'b0;
  assign done    = (MUL_EN != 0) ? done_q : 1'b0;

endmodule
